// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, A/B operand capture, ALU handshake.
// Optional OPF_BYPASS_EN: operands track write-back snoops until consumed.
module operand_fetch #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rn1,
  input  logic [ADDR_W-1:0] req_rn2,
  output logic [ADDR_W-1:0] RN1,
  output logic [ADDR_W-1:0] RN2,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_wn,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_rn1,
  output logic [ADDR_W-1:0] out_rn2
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] CAPT  = 2'd2;
  localparam logic [1:0] VALID = 2'd3;

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(ZERO_REG);

  logic [1:0]        state;
  logic [DATA_W-1:0] sel1;
  logic [DATA_W-1:0] sel2;
  logic              hit1;
  logic              hit2;

  assign req_ready = (state == IDLE);
  assign sel1 = (RN1 == XZR) ? '0 : RD1;
  assign sel2 = (RN2 == XZR) ? '0 : RD2;

`ifdef OPF_BYPASS_EN
  assign hit1 = wb_we && (wb_wn == RN1) && (RN1 != XZR);
  assign hit2 = wb_we && (wb_wn == RN2) && (RN2 != XZR);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_wn, wb_wd};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // Handshake FSM with read-address and operand capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      RN1       <= '0;
      RN2       <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_rn1   <= '0;
      out_rn2   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            RN1   <= req_rn1;
            RN2   <= req_rn2;
            state <= READ;
          end
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          out_a     <= hit1 ? wb_wd : sel1;
          out_b     <= hit2 ? wb_wd : sel2;
          out_rn1   <= RN1;
          out_rn2   <= RN2;
          out_valid <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          if (hit1) out_a <= wb_wd;
          if (hit2) out_b <= wb_wd;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
